// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one physical-memory port between the icache (fill only) and the
//   dcache (fill or writeback). One requester is granted at a time. The grant
//   is held until physical memory responds. Ties are broken round-robin using
//   last_d_reg, so neither cache can starve.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_pmem_read/address            icache request (address held stable)
//   i_pmem_rdata/resp              icache return data and one-cycle strobe
//   d_pmem_read/write/address      dcache request (read and write exclusive)
//   d_pmem_wdata                   dcache writeback line
//   d_pmem_rdata/resp              dcache return data and one-cycle strobe
//   pmem_read/write/address/wdata  request to physical memory
//   pmem_rdata/resp                physical memory return data and strobe
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state_reg, state_next;
  logic   last_d_reg, last_d_next;
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Return data is unqualified; the resp strobes alone mark it valid.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      last_d_reg <= 1'b1;  // icache wins the first tie after reset
    end else begin
      state_reg  <= state_next;
      last_d_reg <= last_d_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = d_pmem_wdata;  // only meaningful while serving the dcache
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Any pmem_resp seen here is stray and is deliberately dropped.
        if (i_req && d_req) state_next = last_d_reg ? SERVE_I : SERVE_D;
        else if (i_req)     state_next = SERVE_I;
        else if (d_req)     state_next = SERVE_D;
      end
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) begin
          state_next  = IDLE;
          last_d_next = 1'b0;
        end else if (!i_req) begin
          // Requester abandoned the transfer: free the port, keep fairness.
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) begin
          state_next  = IDLE;
          last_d_next = 1'b1;
        end else if (!d_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // While reset is asserted the outputs look idle immediately, so a
    // transfer cut short by reset neither keeps requesting nor receives a
    // resp that lands in the same cycle.
    if (rst) begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
    end
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache miss/writeback interfaces. Sits between the two L1 cache controllers and physical memory (or the next cache level). Grants one requester at a time and holds the grant until physical memory responds. Uses round-robin on contention so neither cache starves.

## Interface
Parameters:
- ADDR_W, 32, byte address width of every memory address port
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache request address; stable while the request is held
- i_pmem_rdata  out  LINE_W  line data to icache
- i_pmem_resp  out  1  one-cycle completion strobe to icache
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache writeback request; never asserted together with d_pmem_read
- d_pmem_address  in  ADDR_W  dcache request address; stable while the request is held
- d_pmem_wdata  in  LINE_W  dcache writeback data; stable while d_pmem_write is held
- d_pmem_rdata  out  LINE_W  line data to dcache
- d_pmem_resp  out  1  one-cycle completion strobe to dcache
- pmem_read  out  1  read request to physical memory
- pmem_write  out  1  write request to physical memory
- pmem_address  out  ADDR_W  address to physical memory
- pmem_wdata  out  LINE_W  write data to physical memory
- pmem_rdata  in  LINE_W  read data from physical memory
- pmem_resp  in  1  completion strobe from physical memory

## Operation
- Registered state: `state` ∈ {IDLE, SERVE_I, SERVE_D}; `last_d` (1 = dcache was granted most recently).
- Requester pending: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- IDLE: all pmem requests 0; both resps 0. Next state:
  - i_req only → SERVE_I; d_req only → SERVE_D.
  - Both pending → SERVE_I if last_d = 1, else SERVE_D.
  - Neither pending → IDLE.
- SERVE_I: pmem_read = i_pmem_read; pmem_write = 0; pmem_address = i_pmem_address. i_pmem_resp = pmem_resp. On pmem_resp → IDLE and last_d ← 0.
- SERVE_D: pmem_read = d_pmem_read; pmem_write = d_pmem_write; pmem_address = d_pmem_address; pmem_wdata = d_pmem_wdata. d_pmem_resp = pmem_resp. On pmem_resp → IDLE and last_d ← 1.
- Abort: if the granted requester drops its request before pmem_resp, go → IDLE in the next cycle, leave last_d unchanged, and forward no resp. This is a protocol violation by the requester and must not hang the arbiter.
- i_pmem_rdata and d_pmem_rdata both equal pmem_rdata combinationally. The resp strobe alone qualifies the data.
- pmem_resp while in IDLE is ignored and is not forwarded.
- A resp is never forwarded to the non-granted requester.
- pmem_wdata is a don't-care outside SERVE_D; drive d_pmem_wdata there.
- pmem_address is 0 in IDLE.

## Timing
- Reset: state ← IDLE, last_d ← 1, so the icache wins the first tie. Outputs during and right after reset: pmem_read = pmem_write = 0, i_pmem_resp = d_pmem_resp = 0, pmem_address = 0.
- Reset mid-transfer: the arbiter returns to IDLE on the next edge, drops all pmem requests, and forwards any concurrent pmem_resp to no one.
- Arbitration latency: a request first seen in IDLE at cycle N drives pmem in cycle N+1.
- A grant spans from the SERVE entry cycle through the pmem_resp cycle inclusive. The resp is forwarded in that same cycle, with zero added latency.
- After every resp there is one mandatory IDLE cycle before any new grant. A request that is still high in that IDLE cycle is treated as a new request; the dcache writeback-then-fill sequence relies on this.
- All pmem outputs decode combinationally from `state` and the granted requester's inputs. There is no registered data path.
- Back-to-back requests from both caches alternate: D, I, D, I…

## Test plan
- Lone icache miss: i_pmem_read = 1, addr 0x0000_1000; pmem_resp after 5 cycles with rdata = 0xA5…A5 → pmem_read high from cycle 1, i_pmem_resp = 1 for exactly one cycle with i_pmem_rdata = 0xA5…A5, d_pmem_resp stays 0.
- Dcache dirty eviction: d_pmem_write, addr 0x0000_2000, wdata 0x1234…; resp; then d_pmem_read, addr 0x0000_4000 → first a pmem_write with the correct wdata, then one IDLE cycle, then a pmem_read at 0x0000_4000, with two separate d_pmem_resp pulses.
- Simultaneous requests out of reset: icache 0x100 and dcache 0x200 in the same cycle → icache is served first, then dcache. Verify the grant order by the pmem_address sequence 0x100, 0x200.
- Fairness: dcache requests continuously and icache is held pending → grants alternate D, I, D, I over 4 transfers.
- Reset mid-grant: assert rst during SERVE_D before pmem_resp → pmem_read and pmem_write are 0 on the next cycle, and a pmem_resp arriving in the same cycle is not forwarded.
- Abort: icache drops i_pmem_read in the 2nd grant cycle → the arbiter is back in IDLE the next cycle, no resp is forwarded, and a subsequent dcache request is granted normally.
